ibex_sram_arbiter: RTL

- Shares one single-port SRAM between the Ibex instruction-fetch port and data port.
- Uses the Ibex req/gnt/rvalid protocol on both sides.
- Arbitrates requests, decodes the address window, and routes read data and responses back to the granted requester.
- Sits between ibex_top and a single-port RAM, replacing the dual-port RAM when the FPGA target needs to save BRAM.

---
 rtl/ibex_sram_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/ibex_sram_arbiter.sv
// Shares one single-port SRAM between the Ibex fetch and data ports.
// IBEX_SRAM_ARB_RR_EN selects round-robin instead of data priority.
module ibex_sram_arbiter #(
  parameter int unsigned MemSize  = 65536,
  parameter logic [31:0] MemStart = 32'h0000_0000,
  parameter int unsigned MaxWait  = 4,
  localparam int unsigned AddrW   = $clog2(MemSize / 4)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             instr_req_i,
  input  logic [31:0]      instr_addr_i,
  output logic             instr_gnt_o,
  output logic             instr_rvalid_o,
  output logic [31:0]      instr_rdata_o,
  output logic             instr_err_o,
  input  logic             data_req_i,
  input  logic             data_we_i,
  input  logic [3:0]       data_be_i,
  input  logic [31:0]      data_addr_i,
  input  logic [31:0]      data_wdata_i,
  output logic             data_gnt_o,
  output logic             data_rvalid_o,
  output logic [31:0]      data_rdata_o,
  output logic             data_err_o,
  output logic             ram_req_o,
  output logic             ram_we_o,
  output logic [3:0]       ram_be_o,
  output logic [AddrW-1:0] ram_addr_o,
  output logic [31:0]      ram_wdata_o,
  input  logic [31:0]      ram_rdata_i
);

  localparam logic [31:0] Mask = ~(32'(MemSize) - 32'd1);

  logic        instr_win;
  logic        instr_gnt;
  logic        data_gnt;
  logic [31:0] gnt_addr;
  logic        in_range;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_instr_q, rsp_instr_d;
  logic        rsp_err_q, rsp_err_d;

`ifdef IBEX_SRAM_ARB_RR_EN
  logic last_data_q, last_data_d;

  always_comb begin
    if (instr_req_i && data_req_i) begin
      instr_win = last_data_q;
    end else begin
      instr_win = instr_req_i;
    end
    last_data_d = last_data_q;
    if (instr_gnt) begin
      last_data_d = 1'b0;
    end else if (data_gnt) begin
      last_data_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_data_q <= 1'b1;
    end else begin
      last_data_q <= last_data_d;
    end
  end
`else
  localparam logic [3:0] MaxW = 4'(MaxWait);
  logic [3:0] wait_q, wait_d;

  always_comb begin
    instr_win = instr_req_i &&
                (!data_req_i || (wait_q == MaxW));
    wait_d = 4'd0;
    if (instr_req_i && !instr_gnt) begin
      wait_d = (wait_q == MaxW) ? wait_q : wait_q + 4'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wait_q <= 4'd0;
    end else begin
      wait_q <= wait_d;
    end
  end
`endif

  // Grants are suppressed while reset is held so nothing reaches the RAM.
  always_comb begin
    instr_gnt = instr_win && !rst_i;
    data_gnt  = data_req_i && !instr_win && !rst_i;
    gnt_addr  = instr_gnt ? instr_addr_i : data_addr_i;
    in_range  = ((gnt_addr & Mask) == MemStart);
  end

  logic unused_addr_lsb;
  assign unused_addr_lsb = ^gnt_addr[1:0];

  assign instr_gnt_o = instr_gnt;
  assign data_gnt_o  = data_gnt;
  assign ram_req_o   = (instr_gnt || data_gnt) && in_range;
  assign ram_we_o    = ram_req_o && data_gnt && data_we_i;
  assign ram_be_o    = (ram_req_o && data_gnt) ? data_be_i : 4'h0;
  assign ram_wdata_o = (ram_req_o && data_gnt) ? data_wdata_i : 32'h0;
  assign ram_addr_o  = gnt_addr[AddrW+1:2];

  always_comb begin
    rsp_valid_d = instr_gnt || data_gnt;
    rsp_instr_d = instr_gnt;
    rsp_err_d   = rsp_valid_d && !in_range;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_valid_q <= 1'b0;
      rsp_instr_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_instr_q <= rsp_instr_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // A response still in flight when reset rises is never shown.
  assign instr_rvalid_o = rsp_valid_q && rsp_instr_q && !rst_i;
  assign data_rvalid_o  = rsp_valid_q && !rsp_instr_q && !rst_i;
  assign instr_err_o    = instr_rvalid_o && rsp_err_q;
  assign data_err_o     = data_rvalid_o && rsp_err_q;
  assign instr_rdata_o  = (instr_rvalid_o && !rsp_err_q) ?
                          ram_rdata_i : 32'h0;
  assign data_rdata_o   = (data_rvalid_o && !rsp_err_q) ?
                          ram_rdata_i : 32'h0;

endmodule
